// File: rtl/pipelined_datapath.sv
// Three-stage datapath: combinational issue/forwarding, registered EX (ALU inputs),
// registered WB (result + register bank write). Full EX/WB operand forwarding.
module pipelined_datapath #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    input  logic [AW-1:0]    addr_d,
    input  logic [WIDTH-1:0] immed,
    input  logic             y_sel,
    input  logic             write,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] w_out,
    output logic [AW-1:0]    out_addr
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] regs [NREGS];

    logic             ex_valid;
    logic [3:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_y;
    logic [AW-1:0]    ex_addr;
    logic             ex_write;

    logic             wb_valid;
    logic [WIDTH-1:0] wb_result;
    logic [AW-1:0]    wb_addr;
    logic             wb_write;

    logic [WIDTH-1:0] alu_result;
    logic [SW-1:0]    sh;
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];
    logic [WIDTH-1:0] y_val;

    // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
    // in_ready is simply !stall, and the issuer must hold its fields until taken.
    assign in_ready = !stall;

    assign rd_addr[0] = addr_a;
    assign rd_addr[1] = addr_b;

    // EX is the younger result, so it outranks WB; register 0 overrides everything.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_data[i] = regs[rd_addr[i]];
            if (ex_valid && ex_write && ex_addr == rd_addr[i]) begin
                rd_data[i] = alu_result;
            end else if (wb_valid && wb_write && wb_addr == rd_addr[i]) begin
                rd_data[i] = wb_result;
            end
            if (ZERO_REG != 0 && rd_addr[i] == '0) begin
                rd_data[i] = '0;
            end
        end
    end

    assign a_out = rd_data[0];
    assign b_out = rd_data[1];
    assign y_val = y_sel ? rd_data[1] : immed;

    always_comb begin
        alu_result = '0;
        sh         = ex_y[SW-1:0];
        case (ex_op)
            4'd0:    alu_result = ex_a + ex_y;
            4'd1:    alu_result = ex_a - ex_y;
            4'd2:    alu_result = ex_a & ex_y;
            4'd3:    alu_result = ex_a | ex_y;
            4'd4:    alu_result = ex_a ^ ex_y;
            4'd5:    alu_result = ex_a << sh;
            4'd6:    alu_result = ex_a >> sh;
            4'd7:    alu_result = $signed(ex_a) >>> sh;
            4'd8:    alu_result = {{(WIDTH-1){1'b0}}, $signed(ex_a) < $signed(ex_y)};
            4'd9:    alu_result = {{(WIDTH-1){1'b0}}, ex_a < ex_y};
            4'd10:   alu_result = ex_y;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_a      <= '0;
            ex_y      <= '0;
            ex_addr   <= '0;
            ex_write  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_addr   <= '0;
            wb_write  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (!stall) begin
            ex_valid  <= in_valid;
            ex_op     <= op;
            ex_a      <= rd_data[0];
            ex_y      <= y_val;
            ex_addr   <= addr_d;
            ex_write  <= write;
            wb_valid  <= ex_valid;
            wb_result <= alu_result;
            wb_addr   <= ex_addr;
            wb_write  <= ex_write;
            if (wb_valid && wb_write && !(ZERO_REG != 0 && wb_addr == '0)) begin
                regs[wb_addr] <= wb_result;
            end
        end
    end

    assign out_valid = wb_valid;
    assign w_out     = wb_result;
    assign out_addr  = wb_addr;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: an in-order architectural model predicts each
// result at issue time; a monitor pops and compares as WB presents results.
module tb_pipelined_datapath;
    localparam int W  = 32;
    localparam int NR = 32;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_PASSY = 4'd10;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         stall;
    logic [3:0]   op;
    logic [4:0]   addr_a, addr_b, addr_d;
    logic [W-1:0] immed;
    logic         y_sel;
    logic         write;
    logic [W-1:0] a_out, b_out;
    logic         out_valid;
    logic [W-1:0] w_out;
    logic [4:0]   out_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_regs [NR];
    logic [W-1:0] exp_q [$];
    logic [4:0]   exp_addr_q [$];
    logic         prev_issue, exp_ov, adv;
    logic [W-1:0] last_w;

    pipelined_datapath #(.WIDTH(W), .NREGS(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
        .immed(immed), .y_sel(y_sel), .write(write), .a_out(a_out), .b_out(b_out),
        .out_valid(out_valid), .w_out(w_out), .out_addr(out_addr)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_read(input int a);
        return (a == 0) ? '0 : model_regs[a];
    endfunction

    function automatic logic [W-1:0] alu_m(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] y);
        int s;
        s = int'(y[4:0]);
        case (o)
            OP_ADD:   return a + y;
            OP_SUB:   return a - y;
            OP_AND:   return a & y;
            OP_OR:    return a | y;
            OP_XOR:   return a ^ y;
            OP_SLL:   return a << s;
            OP_SRL:   return a >> s;
            OP_SRA:   return (a >> s) | (a[W-1] ? ~({W{1'b1}} >> s) : '0);
            OP_SLT:   return (a[W-1] != y[W-1]) ? W'(a[W-1]) : W'(a < y);
            OP_SLTU:  return W'(a < y);
            OP_PASSY: return y;
            default:  return '0;
        endcase
    endfunction

    // issue tracking: a result is due in WB one advancing edge after EX
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_issue <= 1'b0;
            exp_ov     <= 1'b0;
            adv        <= 1'b0;
        end else begin
            adv <= !stall;
            if (!stall) begin
                exp_ov     <= prev_issue;
                prev_issue <= in_valid;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [4:0]   ea;
        if (reset === 1'b1) begin
            check_val("out_valid", W'(out_valid), W'(exp_ov));
            if (exp_ov && adv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: got result %h with no expected entry", w_out);
                end else begin
                    e  = exp_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    check_val("w_out", w_out, e);
                    check_val("out_addr", W'(out_addr), W'(ea));
                    last_w <= e;
                end
            end else if (exp_ov) begin
                check_val("w_out_stalled", w_out, last_w);
            end
        end
    end

    // driver: present instruction, optionally hold it under stall, then let it issue
    task automatic issue(input logic [3:0] o, input int a, input int b, input int d,
                         input logic [W-1:0] imm, input logic ys, input logic wr, input int nstall);
        logic [W-1:0] av, bv, yv, r;
        @(posedge clk);
        #1;
        op = o; addr_a = 5'(a); addr_b = 5'(b); addr_d = 5'(d);
        immed = imm; y_sel = ys; write = wr; in_valid = 1'b1;
        stall = (nstall > 0);
        if (nstall > 0) begin
            #1 check_val("in_ready_stall", W'(in_ready), '0);
            repeat (nstall) @(posedge clk);
            #1 stall = 1'b0;
        end
        #1;
        av = model_read(a);
        bv = model_read(b);
        yv = ys ? bv : imm;
        r  = alu_m(o, av, yv);
        check_val("a_out", a_out, av);
        check_val("b_out", b_out, bv);
        exp_q.push_back(r);
        exp_addr_q.push_back(5'(d));
        if (wr && d != 0) model_regs[d] = r;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic check_reg(input int a, input logic [W-1:0] exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        addr_a = 5'(a);
        #1 check_val("reg_read", a_out, exp);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; in_valid = 1'b0; op = '0;
        addr_a = '0; addr_b = '0; addr_d = '0; immed = '0; y_sel = 1'b0; write = 1'b0;
        for (int i = 0; i < NR; i++) model_regs[i] = '0;

        // reset state
        #12;
        check_val("rst_out_valid", W'(out_valid), '0);
        check_val("rst_w_out", w_out, '0);
        check_val("rst_out_addr", W'(out_addr), '0);
        check_val("rst_in_ready", W'(in_ready), W'(1));
        stall = 1'b1;
        #1 check_val("rst_in_ready_stall", W'(in_ready), '0);
        stall = 1'b0;
        #9 reset = 1'b1;

        // immediates into r1, r2
        issue(OP_PASSY, 0, 0, 1, 32'd5, 1'b0, 1'b1, 0);
        issue(OP_PASSY, 0, 0, 2, 32'd7, 1'b0, 1'b1, 0);
        idle(4);
        check_reg(1, 32'd5);
        check_reg(2, 32'd7);

        // dependency chain through EX forward
        issue(OP_ADD, 1, 2, 3, 32'd0, 1'b1, 1'b1, 0);
        issue(OP_SUB, 3, 0, 4, 32'd2, 1'b0, 1'b1, 0);
        idle(4);
        check_reg(3, 32'd12);
        check_reg(4, 32'd10);

        // register 0
        issue(OP_PASSY, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        issue(OP_OR, 0, 0, 5, 32'd3, 1'b0, 1'b1, 0);
        idle(4);
        check_reg(5, 32'd3);
        check_reg(0, 32'd0);

        // shifts, compares, wraparound
        issue(OP_PASSY, 0, 0, 6, 32'h8000_0000, 1'b0, 1'b1, 0);
        issue(OP_SRA, 6, 0, 9, 32'd4, 1'b0, 1'b1, 0);
        issue(OP_SRL, 6, 0, 10, 32'd4, 1'b0, 1'b1, 0);
        issue(OP_SLT, 6, 0, 11, 32'd1, 1'b0, 1'b1, 0);
        issue(OP_SLTU, 6, 0, 12, 32'd1, 1'b0, 1'b1, 0);
        issue(OP_PASSY, 0, 0, 13, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        issue(OP_ADD, 13, 0, 14, 32'd1, 1'b0, 1'b1, 0);
        issue(4'd12, 13, 13, 15, 32'd9, 1'b1, 1'b1, 0);
        idle(4);
        check_reg(9, 32'hF800_0000);
        check_reg(10, 32'h0800_0000);
        check_reg(11, 32'd1);
        check_reg(12, 32'd0);
        check_reg(14, 32'd0);
        check_reg(15, 32'd0);

        // stall with EX and WB both occupied
        issue(OP_PASSY, 0, 0, 16, 32'd21, 1'b0, 1'b1, 0);
        issue(OP_PASSY, 0, 0, 17, 32'd22, 1'b0, 1'b1, 0);
        issue(OP_ADD, 16, 17, 18, 32'd0, 1'b1, 1'b1, 3);
        issue(OP_SUB, 18, 16, 19, 32'd0, 1'b1, 1'b1, 0);
        idle(4);
        check_reg(18, 32'd43);
        check_reg(19, 32'd22);

        // random traffic with occasional stalls
        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        idle(4);

        // asynchronous reset with two instructions in flight
        issue(OP_PASSY, 0, 0, 7, 32'd9, 1'b0, 1'b1, 0);
        issue(OP_PASSY, 0, 0, 8, 32'd11, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("arst_out_valid", W'(out_valid), '0);
        check_val("arst_w_out", w_out, '0);
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        exp_q.delete();
        exp_addr_q.delete();
        #10 reset = 1'b1;
        check_reg(7, 32'd0);
        check_reg(8, 32'd0);
        issue(OP_PASSY, 0, 0, 7, 32'd13, 1'b0, 1'b1, 0);
        issue(OP_ADD, 7, 0, 8, 32'd1, 1'b0, 1'b1, 0);
        idle(4);
        check_reg(7, 32'd13);
        check_reg(8, 32'd14);

        check_val("exp_q_empty", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
